// File: rtl/tm_display_pkg.sv
// rtl/tm_display_pkg.sv - shared frame width, serializer state encoding and frame packing
package tm_display_pkg;

  localparam int FRAME_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } ser_state_t;

  // Frame layout seen by the LED drivers: halt flag, core state, tape window
  function automatic logic [FRAME_W-1:0] pack_frame(
    input logic        done,
    input logic [3:0]  core_state,
    input logic [10:0] window
  );
    return {done, core_state, window};
  endfunction

endpackage

// File: rtl/serial_tick_gen.sv
// rtl/serial_tick_gen.sv - divides the system clock into sclk half-period ticks
module serial_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  assign tick = en && (count == LAST);

  // Count 0..DIV-1 while enabled; idle holds the counter at zero
  always_ff @(posedge clock) begin
    if (reset || !en || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/tape_frame_serializer.sv
// rtl/tape_frame_serializer.sv - packs core status into a frame and shifts it to 74HC595-style drivers
module tape_frame_serializer #(
  parameter int DIV     = 4,
  parameter int FRAME_W = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [10:0] display_out,
  input  logic [3:0]  currState,
  input  logic        Compute_done,
  output logic        sclk,
  output logic        sdata,
  output logic        slatch,
  output logic        busy,
  output logic [7:0]  frames_sent
);

  import tm_display_pkg::*;

  ser_state_t         state;
  ser_state_t         state_next;
  logic [FRAME_W-1:0] live_frame;
  logic [FRAME_W-1:0] last_sent;
  logic [FRAME_W-1:0] shift_reg;
  logic               force_send;
  logic [3:0]         bit_cnt;
  logic               tick;
  logic               tick_en;
  logic               capture;
  logic               shift_step;
  logic               frame_done;

  assign live_frame = pack_frame(Compute_done, currState, display_out);
  assign tick_en    = (state != IDLE);

  serial_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clock (clock),
    .reset (reset),
    .en    (tick_en),
    .tick  (tick)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, datapath strobes and pin levels decoded from the current state
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    shift_step = 1'b0;
    frame_done = 1'b0;
    sclk       = 1'b0;
    sdata      = 1'b0;
    slatch     = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (force_send || (live_frame != last_sent)) begin
          capture    = 1'b1;
          state_next = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        sdata = shift_reg[FRAME_W-1];
        if (tick) begin
          state_next = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        sclk  = 1'b1;
        sdata = shift_reg[FRAME_W-1];
        if (tick) begin
          shift_step = 1'b1;
          state_next = (bit_cnt == 4'd15) ? LATCH : SHIFT_LO;
        end
      end
      LATCH: begin
        slatch = 1'b1;
        if (tick) begin
          frame_done = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Frame capture, shifting and the completed-frame counter; force makes the first frame after reset unconditional
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_reg   <= '0;
      last_sent   <= '0;
      force_send  <= 1'b1;
      bit_cnt     <= 4'd0;
      frames_sent <= 8'd0;
    end else begin
      if (capture) begin
        shift_reg  <= live_frame;
        last_sent  <= live_frame;
        force_send <= 1'b0;
        bit_cnt    <= 4'd0;
      end else if (shift_step) begin
        shift_reg <= shift_reg << 1;
        bit_cnt   <= bit_cnt + 4'd1;
      end
      if (frame_done) begin
        frames_sent <= frames_sent + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_tape_frame_serializer.sv
// tb/tb_tape_frame_serializer.sv - scoreboard bench for tape_frame_serializer
module tb_tape_frame_serializer;

  localparam int DIV_M = 2;

  typedef struct packed {
    logic [15:0] f;
    logic [7:0]  seq;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [10:0] disp;
  logic [3:0]  cst;
  logic        cdone;
  logic        sclk, sdata, slatch, busy;
  logic [7:0]  frames_sent;

  logic        reset1;
  logic [10:0] disp1;
  logic [3:0]  cst1;
  logic        cdone1;
  logic        sclk1, sdata1, slatch1, busy1;
  logic [7:0]  frames_sent1;

  int total = 0;
  int bad   = 0;

  exp_t        expq[$];
  logic [15:0] mid_q[$];
  logic [15:0] model_last;
  logic [7:0]  push_count;

  logic        prev_sclk, prev_slatch, prev_busy;
  int          nbits, hi_len, latch_len, busy_len;
  logic [15:0] bits;
  logic [7:0]  cur_seq;
  bit          have_exp;

  always #5 clock = ~clock;

  tape_frame_serializer #(.DIV(DIV_M), .FRAME_W(16)) dut (
    .clock(clock), .reset(reset), .display_out(disp), .currState(cst),
    .Compute_done(cdone), .sclk(sclk), .sdata(sdata), .slatch(slatch),
    .busy(busy), .frames_sent(frames_sent)
  );

  tape_frame_serializer #(.DIV(1), .FRAME_W(16)) dut1 (
    .clock(clock), .reset(reset1), .display_out(disp1), .currState(cst1),
    .Compute_done(cdone1), .sclk(sclk1), .sdata(sdata1), .slatch(slatch1),
    .busy(busy1), .frames_sent(frames_sent1)
  );

  function automatic logic [15:0] tb_pack(input logic d, input logic [3:0] s, input logic [10:0] w);
    return {d, s, w};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [15:0] f);
    exp_t e;
    push_count = push_count + 8'd1;
    e.f   = f;
    e.seq = push_count;
    expq.push_back(e);
  endtask

  task automatic drive_frame(input logic [15:0] f);
    @(posedge clock);
    #1;
    cdone = f[15];
    cst   = f[14:11];
    disp  = f[10:0];
  endtask

  task automatic wait_quiet();
    int q = 0;
    int n = 0;
    while (q < 4 && n < 600) begin
      @(negedge clock);
      n++;
      if (busy) q = 0;
      else q++;
    end
    if (q < 4) chk("quiet_timeout", 32'(n), 32'd0);
  endtask

  // Frame change rule: a new frame goes out when the value seen at a transfer boundary differs from the last one sent
  task automatic episode(input logic [15:0] f0);
    logic [15:0] cur;
    bit started;
    drive_frame(f0);
    started = (f0 != model_last);
    cur = f0;
    if (started) begin
      push_exp(f0);
      model_last = f0;
      repeat (3) @(posedge clock);
      foreach (mid_q[i]) begin
        drive_frame(mid_q[i]);
        cur = mid_q[i];
        repeat ($urandom_range(0, 4)) @(posedge clock);
      end
      if (cur != model_last) begin
        push_exp(cur);
        model_last = cur;
      end
    end
    mid_q.delete();
    wait_quiet();
  endtask

  // Monitor: rebuild frames from sclk rises, compare against the scoreboard on each latch pulse
  always @(negedge clock) begin
    if (reset) begin
      nbits = 0; hi_len = 0; latch_len = 0; busy_len = 0; bits = '0;
      prev_sclk = 0; prev_slatch = 0; prev_busy = 0; have_exp = 0;
    end else begin
      if (sclk && !prev_sclk) begin
        bits = {bits[14:0], sdata};
        nbits++;
      end
      if (sclk) hi_len++;
      if (!sclk && prev_sclk) begin
        if (hi_len != DIV_M) chk("sclk_high_len", 32'(hi_len), 32'(DIV_M));
        hi_len = 0;
      end
      if (slatch && !prev_slatch) begin
        chk("bits_per_frame", 32'(nbits), 32'd16);
        if (expq.size() == 0) begin
          chk("unexpected_frame", {16'd0, bits}, 32'hFFFF_FFFF);
          have_exp = 0;
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("frame_data", {16'd0, bits}, {16'd0, e.f});
          cur_seq  = e.seq;
          have_exp = 1;
        end
        latch_len = 0;
      end
      if (slatch) latch_len++;
      if (!slatch && prev_slatch) begin
        chk("slatch_len", 32'(latch_len), 32'(DIV_M));
        if (have_exp) chk("frames_sent_at_latch", {24'd0, frames_sent}, {24'd0, cur_seq});
        nbits = 0;
      end
      if (busy) busy_len++;
      if (!busy && prev_busy) begin
        chk("busy_len", 32'(busy_len), 32'(33 * DIV_M));
        busy_len = 0;
      end
      prev_sclk = sclk; prev_slatch = slatch; prev_busy = busy;
    end
  end

  initial begin
    reset = 1; disp = '0; cst = '0; cdone = 0;
    reset1 = 1; disp1 = '0; cst1 = '0; cdone1 = 0;
    push_count = 8'd0;
    model_last = 16'h0000;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_sclk", {31'd0, sclk}, 32'd0);
    chk("rst_sdata", {31'd0, sdata}, 32'd0);
    chk("rst_slatch", {31'd0, slatch}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frames_sent", {24'd0, frames_sent}, 32'd0);

    push_exp(16'h0000);
    reset = 0;
    wait_quiet();
    chk("force_frames_sent", {24'd0, frames_sent}, 32'd1);
    repeat (20) @(posedge clock);
    chk("idle_no_extra_q", 32'(expq.size()), 32'd0);
    chk("idle_no_extra_cnt", {24'd0, frames_sent}, 32'd1);

    episode(tb_pack(1'b0, 4'd3, 11'h5A5));
    chk("frame_1da5_cnt", {24'd0, frames_sent}, 32'd2);

    mid_q.push_back(tb_pack(1'b1, 4'd4, 11'h0F0));
    mid_q.push_back(tb_pack(1'b1, 4'd5, 11'h0F0));
    episode(tb_pack(1'b1, 4'd3, 11'h0F0));
    chk("collapse_cnt", {24'd0, frames_sent}, 32'd4);

    mid_q.push_back(tb_pack(1'b0, 4'd2, 11'h2AB));
    mid_q.push_back(tb_pack(1'b0, 4'd2, 11'h2AA));
    episode(tb_pack(1'b0, 4'd2, 11'h2AA));
    chk("revert_cnt", {24'd0, frames_sent}, 32'd5);

    for (int k = 0; k < 24; k++) begin
      logic [15:0] f;
      f = 16'($urandom);
      if ($urandom_range(0, 3) == 0) f = model_last;
      for (int m = 0; m < int'($urandom_range(0, 3)); m++) begin
        if ($urandom_range(0, 2) == 0) mid_q.push_back(model_last);
        else mid_q.push_back(16'($urandom));
      end
      episode(f);
    end
    chk("random_cnt", {24'd0, frames_sent}, {24'd0, push_count});

    begin : reset_mid
      int n = 0;
      logic [15:0] f;
      f = model_last ^ 16'h4321;
      drive_frame(f);
      push_exp(f);
      model_last = f;
      while (nbits != 7 && n < 300) begin
        @(negedge clock);
        n++;
      end
      if (nbits != 7) chk("bit7_timeout", 32'(n), 32'd0);
      @(posedge clock);
      #1;
      reset = 1;
      @(posedge clock);
      #1;
      chk("midrst_sclk", {31'd0, sclk}, 32'd0);
      chk("midrst_sdata", {31'd0, sdata}, 32'd0);
      chk("midrst_slatch", {31'd0, slatch}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_frames_sent", {24'd0, frames_sent}, 32'd0);
      expq.delete();
      push_count = 8'd0;
      @(posedge clock);
      #1;
      push_exp(f);
      reset = 0;
      wait_quiet();
      chk("after_rst_cnt", {24'd0, frames_sent}, 32'd1);
    end

    for (int k = 0; k < 255; k++) begin
      episode(model_last ^ 16'h8000);
    end
    chk("wrap_cnt", {24'd0, frames_sent}, 32'd0);
    chk("wrap_queue", 32'(expq.size()), 32'd0);

    begin : div1
      int bcyc = 0;
      int rises = 0;
      int hic = 0;
      int lat = 0;
      logic [15:0] b1 = '0;
      logic p = 0;
      logic [15:0] r;
      r = 16'($urandom);
      cdone1 = r[15]; cst1 = r[14:11]; disp1 = r[10:0];
      @(posedge clock);
      #1;
      reset1 = 0;
      repeat (60) begin
        @(negedge clock);
        if (busy1) bcyc++;
        if (sclk1) hic++;
        if (sclk1 && !p) begin
          rises++;
          b1 = {b1[14:0], sdata1};
        end
        p = sclk1;
        if (slatch1) lat++;
      end
      chk("div1_busy_cycles", 32'(bcyc), 32'd33);
      chk("div1_rises", 32'(rises), 32'd16);
      chk("div1_sclk_high", 32'(hic), 32'd16);
      chk("div1_latch_len", 32'(lat), 32'd1);
      chk("div1_frame", {16'd0, b1}, {16'd0, r});
      chk("div1_frames_sent", {24'd0, frames_sent1}, 32'd1);
    end

    chk("final_queue_empty", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
